// File: rtl/count_pkg.sv
// count_pkg: width constants and feeder state encoding shared with the count engine
package count_pkg;
  localparam int LINE_W = 512;
  localparam int CNT_W = 32;
  localparam int LANES = LINE_W / 32;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, REPORT} feeder_state_e;
endpackage

// File: rtl/count_feeder_if.sv
// count_feeder_if: job, line, engine and total signals of the feeder; master is the feeder side
interface count_feeder_if;
  import count_pkg::*;
  logic cfg_valid;
  logic cfg_ready;
  logic [CNT_W-1:0] cfg_object;
  logic [CNT_W-1:0] cfg_num_lines;
  logic line_valid;
  logic line_ready;
  logic [LINE_W-1:0] line_data;
  logic eng_start;
  logic [LINE_W-1:0] eng_data_set;
  logic [CNT_W-1:0] eng_object;
  logic eng_done;
  logic [CNT_W-1:0] eng_result;
  logic total_valid;
  logic [CNT_W-1:0] total;
  logic total_ack;
  logic sat;
  logic stray_done;
  modport master (
    input cfg_valid, cfg_object, cfg_num_lines, line_valid, line_data, eng_done, eng_result, total_ack,
    output cfg_ready, line_ready, eng_start, eng_data_set, eng_object, total_valid, total, sat, stray_done
  );
  modport slave (
    output cfg_valid, cfg_object, cfg_num_lines, line_valid, line_data, eng_done, eng_result, total_ack,
    input cfg_ready, line_ready, eng_start, eng_data_set, eng_object, total_valid, total, sat, stray_done
  );
endinterface

// File: rtl/count_line_fifo.sv
// count_line_fifo: small synchronous line buffer with wrap-bit pointers
module count_line_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int LINE_W = 512
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic [LINE_W-1:0] din,
  output logic [LINE_W-1:0] dout,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [LINE_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout = mem[rd_ptr[AW-1:0]];
  // pointer update; reset empties the buffer without touching storage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end
  // line storage
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/count_feeder.sv
// count_feeder: buffers job lines, issues them to the count engine and accumulates a saturating total
module count_feeder
  import count_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input logic clk,
  input logic rst,
  count_feeder_if.master bus
);
  feeder_state_e state, state_nx;
  logic [CNT_W-1:0] remaining, to_accept;
  logic [LINE_W-1:0] head;
  logic [CNT_W:0] sum;
  logic push, pop, full, empty, accept, done_ok;
  assign bus.cfg_ready = state == IDLE;
  assign bus.line_ready = (state == ISSUE || state == WAIT) && !full && to_accept != '0;
  assign bus.total_valid = state == REPORT;
  assign push = bus.line_valid && bus.line_ready;
  assign accept = bus.cfg_valid && state == IDLE;
  assign done_ok = bus.eng_done && state == WAIT;
  assign sum = {1'b0, bus.total} + {1'b0, bus.eng_result};
  count_line_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .LINE_W(LINE_W)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(bus.line_data),
    .dout(head), .full(full), .empty(empty)
  );
  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else state <= state_nx;
  end
  // next state; a pop happens only when ISSUE finds a buffered line
  always_comb begin
    state_nx = state;
    pop = 1'b0;
    case (state)
      IDLE: if (bus.cfg_valid) state_nx = bus.cfg_num_lines == '0 ? REPORT : ISSUE;
      ISSUE: begin
        pop = !empty;
        state_nx = empty ? ISSUE : WAIT;
      end
      WAIT: if (bus.eng_done) state_nx = remaining == CNT_W'(1) ? REPORT : ISSUE;
      default: if (bus.total_ack) state_nx = IDLE;
    endcase
  end
  // job bookkeeping, engine operands and saturating accumulation
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.eng_start <= 1'b0;
      bus.eng_data_set <= '0;
      bus.eng_object <= '0;
      bus.total <= '0;
      bus.sat <= 1'b0;
      bus.stray_done <= 1'b0;
      remaining <= '0;
      to_accept <= '0;
    end else begin
      bus.eng_start <= pop;
      if (pop) bus.eng_data_set <= head;
      if (push) to_accept <= to_accept - CNT_W'(1);
      if (accept) begin
        bus.eng_object <= bus.cfg_object;
        remaining <= bus.cfg_num_lines;
        to_accept <= bus.cfg_num_lines;
        bus.total <= '0;
        bus.sat <= 1'b0;
        bus.stray_done <= 1'b0;
      end else if (bus.eng_done && state != WAIT) bus.stray_done <= 1'b1;
      if (done_ok) begin
        bus.total <= sum[CNT_W] ? '1 : sum[CNT_W-1:0];
        bus.sat <= bus.sat | sum[CNT_W];
        remaining <= remaining - CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_count_feeder.sv
// tb_count_feeder: randomized scoreboard bench with a behavioural engine and job-total model
module tb_count_feeder;
  import count_pkg::*;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  count_feeder_if bus();
  count_feeder #(.FIFO_DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total_n = 0;
  int bad_n = 0;
  int eng_lat = 4;
  int starts = 0;
  int jobs_done = 0;
  int njobs = 0;
  int stray_cnt = 0;
  int stalls = 0;
  logic [LINE_W-1:0] line_q[$];
  logic [CNT_W-1:0] obj_q[$];
  logic [CNT_W:0] tot_q[$];
  logic [CNT_W-1:0] force_q[$];
  logic [15:0] mq[$];
  logic [CNT_W-1:0] last_total;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_n++;
    if (act !== exp) begin
      bad_n++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_line(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    total_n++;
    if (act !== exp) begin
      bad_n++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total_n++;
    bad_n++;
    $display("FAIL %s: event not expected or never arrived", name);
  endtask

  function automatic logic [LINE_W-1:0] mk_line(input logic [CNT_W-1:0] obj, input logic [15:0] m);
    logic [LINE_W-1:0] l;
    for (int i = 0; i < LANES; i++) l[i*32 +: 32] = m[i] ? obj : obj ^ (32'($urandom) | 32'h1);
    return l;
  endfunction

  function automatic int lanes(input logic [LINE_W-1:0] l, input logic [CNT_W-1:0] o);
    int c = 0;
    for (int i = 0; i < LANES; i++) if (l[i*32 +: 32] == o) c++;
    return c;
  endfunction

  // engine model plus line-order monitor
  initial begin
    logic busy;
    int cnt;
    logic [LINE_W-1:0] cap;
    logic [CNT_W-1:0] ocap;
    busy = 1'b0;
    cnt = 0;
    bus.eng_done = 1'b0;
    bus.eng_result = '0;
    forever begin
      @(negedge clk);
      bus.eng_done = 1'b0;
      if (!rst) busy = 1'b0;
      else begin
        if (stray_cnt > 0) begin
          stray_cnt--;
          bus.eng_done = 1'b1;
          bus.eng_result = 32'h77;
        end
        if (busy) begin
          cnt--;
          if (cnt == 0) begin
            busy = 1'b0;
            chk_line("hold_data", bus.eng_data_set, cap);
            chk("hold_obj", 64'(bus.eng_object), 64'(ocap));
            bus.eng_done = 1'b1;
            bus.eng_result = force_q.size() > 0 ? force_q.pop_front() : CNT_W'(lanes(cap, ocap));
          end
        end
        if (bus.eng_start) begin
          if (busy || line_q.size() == 0) fail_now("start_unexpected");
          else begin
            starts++;
            busy = 1'b1;
            cnt = eng_lat;
            cap = bus.eng_data_set;
            ocap = bus.eng_object;
            chk_line("line_order", cap, line_q.pop_front());
            chk("line_obj", 64'(ocap), 64'(obj_q.pop_front()));
          end
        end
      end
    end
  end

  // total monitor and acknowledging consumer
  initial begin
    logic [CNT_W:0] e;
    int d;
    bus.total_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (rst && bus.total_valid) begin
        if (tot_q.size() == 0) fail_now("total_unexpected");
        else begin
          e = tot_q.pop_front();
          chk("total", 64'(bus.total), 64'(e[CNT_W-1:0]));
          chk("sat", 64'(bus.sat), 64'(e[CNT_W]));
        end
        d = $urandom_range(0, 3);
        repeat (d) begin
          @(negedge clk);
          chk("total_valid_hold", 64'(bus.total_valid), 64'(1));
        end
        bus.total_ack = 1'b1;
        @(negedge clk);
        bus.total_ack = 1'b0;
        chk("total_valid_clear", 64'(bus.total_valid), 64'(0));
        jobs_done++;
      end
    end
  end

  task automatic start_job(input logic [CNT_W-1:0] obj, input logic [CNT_W-1:0] n);
    bus.cfg_valid = 1'b1;
    bus.cfg_object = obj;
    bus.cfg_num_lines = n;
    #1 chk("cfg_ready", 64'(bus.cfg_ready), 64'(1));
    @(negedge clk);
    bus.cfg_valid = 1'b0;
    chk("stray_clear", 64'(bus.stray_done), 64'(0));
  endtask

  task automatic send_line(input logic [LINE_W-1:0] d);
    logic acc;
    int t;
    t = 0;
    bus.line_valid = 1'b1;
    bus.line_data = d;
    forever begin
      #1 acc = bus.line_ready;
      if (!acc) stalls++;
      @(negedge clk);
      t++;
      if (acc) break;
      if (t > 2000) begin
        fail_now("line_timeout");
        break;
      end
    end
    bus.line_valid = 1'b0;
  endtask

  task automatic job(input logic [CNT_W-1:0] obj, input int nfeed, input int gap, input bit use_force);
    logic [LINE_W-1:0] ln[$];
    logic [LINE_W-1:0] l;
    logic [63:0] sum;
    sum = '0;
    foreach (mq[i]) begin
      l = mk_line(obj, mq[i]);
      ln.push_back(l);
      line_q.push_back(l);
      obj_q.push_back(obj);
      sum += use_force ? 64'(force_q[i]) : 64'($countones(mq[i]));
    end
    last_total = sum > 64'hFFFF_FFFF ? 32'hFFFF_FFFF : sum[31:0];
    tot_q.push_back({sum > 64'hFFFF_FFFF, last_total});
    njobs++;
    start_job(obj, CNT_W'(mq.size()));
    for (int i = 0; i < nfeed; i++) begin
      send_line(ln[i]);
      repeat ($urandom_range(0, gap)) @(negedge clk);
    end
  endtask

  task automatic wait_jobs();
    int t;
    t = 0;
    while (jobs_done < njobs && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("job_complete", 64'(jobs_done), 64'(njobs));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cfg_ready"}, 64'(bus.cfg_ready), 64'(1));
    chk({tag, "_line_ready"}, 64'(bus.line_ready), 64'(0));
    chk({tag, "_eng_start"}, 64'(bus.eng_start), 64'(0));
    chk_line({tag, "_eng_data_set"}, bus.eng_data_set, '0);
    chk({tag, "_eng_object"}, 64'(bus.eng_object), 64'(0));
    chk({tag, "_total"}, 64'(bus.total), 64'(0));
    chk({tag, "_total_valid"}, 64'(bus.total_valid), 64'(0));
    chk({tag, "_sat"}, 64'(bus.sat), 64'(0));
    chk({tag, "_stray"}, 64'(bus.stray_done), 64'(0));
  endtask

  initial begin
    int s0;
    int t;
    logic acc7;
    bus.cfg_valid = 1'b0;
    bus.cfg_object = '0;
    bus.cfg_num_lines = '0;
    bus.line_valid = 1'b0;
    bus.line_data = '0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b1;
    @(negedge clk);
    chk("post_reset_cfg_ready", 64'(bus.cfg_ready), 64'(1));
    chk("post_reset_line_ready", 64'(bus.line_ready), 64'(0));

    s0 = starts;
    eng_lat = 4;
    mq.delete();
    mq.push_back(16'h0003);
    mq.push_back(16'h0000);
    mq.push_back(16'hFFFF);
    job(32'd5, 3, 2, 1'b0);
    wait_jobs();
    chk("single_starts", 64'(starts - s0), 64'(3));

    s0 = starts;
    mq.delete();
    job(32'd7, 0, 0, 1'b0);
    chk("zero_total_valid", 64'(bus.total_valid), 64'(1));
    chk("zero_line_ready", 64'(bus.line_ready), 64'(0));
    wait_jobs();
    chk("zero_no_start", 64'(starts - s0), 64'(0));

    eng_lat = 10;
    mq.delete();
    for (int i = 0; i < 6; i++) mq.push_back(16'($urandom));
    stalls = 0;
    job(32'd9, 6, 0, 1'b0);
    chk("backpressure_stall", 64'(stalls > 0), 64'(1));
    bus.line_valid = 1'b1;
    bus.line_data = mk_line(32'd9, 16'hFFFF);
    acc7 = 1'b0;
    t = 0;
    while (jobs_done < njobs && t < 3000) begin
      #1 if (bus.line_ready) acc7 = 1'b1;
      @(negedge clk);
      t++;
    end
    bus.line_valid = 1'b0;
    chk("no_seventh_line", 64'(acc7), 64'(0));
    wait_jobs();

    eng_lat = 3;
    force_q.push_back(32'hFFFF_FFF0);
    force_q.push_back(32'h0000_0020);
    mq.delete();
    mq.push_back(16'($urandom));
    mq.push_back(16'($urandom));
    job(32'h11, 2, 1, 1'b1);
    wait_jobs();

    stray_cnt = 1;
    repeat (3) @(negedge clk);
    chk("stray_set", 64'(bus.stray_done), 64'(1));
    chk("stray_total_kept", 64'(bus.total), 64'(last_total));
    chk("stray_no_report", 64'(bus.total_valid), 64'(0));

    for (int j = 0; j < 5; j++) begin
      eng_lat = $urandom_range(1, 6);
      mq.delete();
      for (int i = 0; i < int'($urandom_range(1, 5)); i++) mq.push_back(16'($urandom));
      job(32'($urandom), mq.size(), 3, 1'b0);
      wait_jobs();
    end

    eng_lat = 20;
    s0 = starts;
    mq.delete();
    for (int i = 0; i < 4; i++) mq.push_back(16'($urandom));
    job(32'h42, 3, 0, 1'b0);
    repeat (2) @(negedge clk);
    chk("midjob_started", 64'(starts - s0), 64'(1));
    rst = 1'b0;
    #1 chk_reset_outputs("midjob");
    line_q.delete();
    obj_q.delete();
    tot_q.delete();
    force_q.delete();
    njobs--;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int j = 0; j < 3; j++) begin
      eng_lat = $urandom_range(1, 5);
      mq.delete();
      for (int i = 0; i < int'($urandom_range(1, 4)); i++) mq.push_back(16'($urandom));
      job(32'($urandom), mq.size(), 2, 1'b0);
      wait_jobs();
    end
    chk("scoreboard_lines_drained", 64'(line_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/count_feeder.md
# count_feeder

Job-level front end for the `count` match-counting engine. It accepts a job (object value plus line count) and buffers incoming 512-bit data lines from the read path in a small FIFO. It issues each line to the engine with a `start` pulse, waits for `done`, and accumulates the per-line `result` values into a saturating job total. The engine's `start`/`data_set`/`object` ports are driven from this block, and its `done`/`result` ports are consumed here.

## Interface
- `FIFO_DEPTH`, 4: line buffer entries; power of two, ≥2.
- `LINE_W`, 512: data line width; 16 lanes of 32 bits.
- `CNT_W`, 32: width of object, line count, result and total.

- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous assert, active-low; logic is in reset while `rst`=0.
- `cfg_valid`  in  1  job request.
- `cfg_ready`  out  1  job accepted when `cfg_valid && cfg_ready`.
- `cfg_object`  in  CNT_W  value to count.
- `cfg_num_lines`  in  CNT_W  number of lines in the job.
- `line_valid`  in  1  data line offered.
- `line_ready`  out  1  line accepted when `line_valid && line_ready`.
- `line_data`  in  LINE_W  data line.
- `eng_start`  out  1  one-cycle start pulse to the engine.
- `eng_data_set`  out  LINE_W  line under count; registered.
- `eng_object`  out  CNT_W  object under count; registered.
- `eng_done`  in  1  engine completion pulse.
- `eng_result`  in  CNT_W  per-line match count, valid with `eng_done`.
- `total_valid`  out  1  job total available.
- `total`  out  CNT_W  accumulated total.
- `total_ack`  in  1  consumer takes the total.
- `sat`  out  1  total saturated during the current job.
- `stray_done`  out  1  sticky flag: `eng_done` seen outside WAIT.

## Operation
- FSM states: IDLE, ISSUE, WAIT, REPORT.
- **IDLE**
  - `cfg_ready`=1.
  - On handshake: latch `cfg_object` into `eng_object`; set `remaining` and `to_accept` to `cfg_num_lines`; clear `total`, `sat` and `stray_done`.
  - Next state is ISSUE, or REPORT if `cfg_num_lines`=0.
- **Line intake**
  - `line_ready` = (state ∈ {ISSUE, WAIT}) && FIFO not full && `to_accept`≠0.
  - Each accepted line decrements `to_accept`. Extra lines are never accepted.
  - Push and pop in the same cycle are allowed. A line arriving into an empty FIFO is never bypassed.
- **ISSUE**
  - If the FIFO is not empty: pop the head into `eng_data_set`, pulse `eng_start` for 1 cycle, go to WAIT.
  - Otherwise stay in ISSUE.
- **WAIT**
  - Hold `eng_data_set` and `eng_object` stable.
  - On `eng_done`:
    - `total` ← `total` + `eng_result`, saturating at 2^CNT_W−1; set `sat` if clamped.
    - Decrement `remaining`.
    - Go to REPORT if `remaining` was 1, else ISSUE.
- **REPORT**
  - `total_valid`=1, `total` held stable.
  - On `total_ack`: clear `total_valid`, go to IDLE.
- `eng_done` in any state other than WAIT is ignored for accumulation and sets `stray_done`.

## Timing
- Reset values:
  - `eng_start`, `eng_data_set`, `eng_object`, `total`, `total_valid`, `sat`, `stray_done` all 0.
  - FIFO empty, state IDLE.
  - `cfg_ready`=1 and `line_ready`=0 from the first cycle after reset release.
- Reset asserted mid-job: immediate return to reset values. Buffered lines are discarded and the pending engine result is lost.
- `eng_start` rises at the earliest 1 cycle after entering ISSUE with a non-empty FIFO.
- The next `eng_start` comes no earlier than 2 cycles after the `eng_done` cycle, because of the WAIT→ISSUE→start sequence. This guarantees the engine is back in its idle state before the next start.
- `eng_data_set` and `eng_object` must not change from the `eng_start` cycle through the `eng_done` cycle.
- `total_valid` rises the cycle after the final `eng_done` (or after acceptance of a zero-line job) and stays high until `total_ack`.
- `cfg_ready` and `line_ready` are combinational from state and FIFO flags only. There is no combinational path from `cfg_valid`, `line_valid` or `total_ack`.

## Structure
- Shared package `count_pkg`: `LINE_W`, `CNT_W`, and the feeder state enum (IDLE/ISSUE/WAIT/REPORT). The `count` engine uses the same width constants.
- Sub-module `count_line_fifo`: synchronous FIFO parameterised by `FIFO_DEPTH` and `LINE_W`, with push/pop/full/empty and the same asynchronous active-low reset.

## Test plan
- **Single job:** object=5, 3 lines with 2, 0 and 16 lanes equal to 5, engine model with 4-cycle latency -> exactly 3 `eng_start` pulses, `total`=18, `sat`=0, `total_valid` held until `total_ack`.
- **Zero-line job:** `cfg_num_lines`=0 -> no `eng_start`, `line_ready` never high, `total_valid`=1 with `total`=0 on the next cycle.
- **Backpressure and overflow:** 6 lines offered back-to-back with `FIFO_DEPTH`=4 and `cfg_num_lines`=6 -> `line_ready` drops when the FIFO is full, all 6 lines are counted in order, and a 7th offered line is not accepted.
- **Saturation:** preload a job whose cumulative results exceed 2^32−1 (engine model returns 0xFFFF_FFF0, then 0x20) -> `total`=0xFFFF_FFFF, `sat`=1.
- **Stray done:** pulse `eng_done` while in IDLE -> `stray_done`=1, `total` unchanged; the flag clears on the next job accept.
- **Reset mid-job:** assert `rst`=0 during WAIT with 2 lines buffered -> all outputs go to reset values, the FIFO is empty, and a new job afterwards produces the correct total.
